dsp_ctr_nd: RTL

- Parametrised successor to the single DSP counter: NUM_DIMS nested up-counters with a carry chain. Dim 0 is innermost; each dim has its own loadable end value.
- Adds start/restart control, wrap or one-shot mode, per-dimension pipelined wrap events and busy/done status.
- Sits in the TPU control path as the loop/address generator for weight, activation and accumulator tile sweeps.

---
 rtl/dsp_ctr_nd.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dsp_ctr_nd.sv
// dsp_ctr_nd: NUM_DIMS nested up-counters with a carry chain and loadable end values.
// Wrap or one-shot run control, enable-gated wrap event pipeline, busy/done status.
module dsp_ctr_nd #(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_DIMS      = 3,
    parameter int EVENT_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              start,
    input  logic                              mode,
    input  logic                              load,
    input  logic [NUM_DIMS*COUNTER_WIDTH-1:0] end_val,
    output logic [NUM_DIMS*COUNTER_WIDTH-1:0] ctr_val,
    output logic [NUM_DIMS-1:0]               ctr_event,
    output logic                              busy,
    output logic                              done
);

    localparam int W  = COUNTER_WIDTH;
    localparam int ND = NUM_DIMS;
    localparam int VW = NUM_DIMS * COUNTER_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [VW-1:0]   ctr_r;
    logic [VW-1:0]   ctr_s;
    logic [VW-1:0]   end_r;
    logic            mode_r;
    logic            mode_s;
    logic            busy_r;
    logic            done_r;
    logic            done_s;
    logic [ND-1:0]   at_end_s;
    logic [ND-1:0]   carry_s;
    logic [ND-1:0]   ev_raw_s;
    logic            carry_acc_s;
    logic            terminal_s;
    logic [ND-1:0]   ev_pipe_r [EVENT_LATENCY];

    // Per-dimension end compare and ripple carry; >= forces a wrap when end is lowered mid-run.
    always_comb begin
        at_end_s    = {ND{1'b0}};
        carry_s     = {ND{1'b0}};
        carry_acc_s = (state_r == ST_RUN) && enable && !start;
        for (int d = 0; d < ND; d++) begin
            at_end_s[d] = (ctr_r[d*W +: W] >= end_r[d*W +: W]);
            carry_s[d]  = carry_acc_s;
            carry_acc_s = carry_acc_s & at_end_s[d];
        end
        ev_raw_s   = carry_s & at_end_s;
        terminal_s = ev_raw_s[ND-1];
    end

    // Next-state, counter update and done generation; start overrides counting.
    always_comb begin
        state_s = state_r;
        ctr_s   = ctr_r;
        mode_s  = mode_r;
        done_s  = 1'b0;
        if (start) begin
            state_s = ST_RUN;
            ctr_s   = {VW{1'b0}};
            mode_s  = mode;
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (carry_s[d]) begin
                    if (at_end_s[d]) begin
                        ctr_s[d*W +: W] = {W{1'b0}};
                    end else begin
                        ctr_s[d*W +: W] = ctr_r[d*W +: W] + W'(1'b1);
                    end
                end else begin
                    ctr_s[d*W +: W] = ctr_r[d*W +: W];
                end
            end
            case (state_r)
                ST_RUN: begin
                    if (terminal_s && mode_r) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Run-state, counters and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ctr_r   <= {VW{1'b0}};
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ctr_r   <= ctr_s;
            mode_r  <= mode_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= done_s;
        end
    end

    // End-value register loads on any cycle regardless of enable or state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            end_r <= {VW{1'b0}};
        end else if (load) begin
            end_r <= end_val;
        end else begin
            end_r <= end_r;
        end
    end

    // Wrap event delay line; advances only on enabled cycles and is never flushed by start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < EVENT_LATENCY; i++) begin
                ev_pipe_r[i] <= {ND{1'b0}};
            end
        end else if (enable) begin
            ev_pipe_r[0] <= ev_raw_s;
            for (int i = 1; i < EVENT_LATENCY; i++) begin
                ev_pipe_r[i] <= ev_pipe_r[i-1];
            end
        end else begin
            for (int i = 0; i < EVENT_LATENCY; i++) begin
                ev_pipe_r[i] <= ev_pipe_r[i];
            end
        end
    end

    assign ctr_val   = ctr_r;
    assign ctr_event = ev_pipe_r[EVENT_LATENCY-1];
    assign busy      = busy_r;
    assign done      = done_r;

    dsp_ctr_nd_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_r),
        .done (done_r)
    );

endmodule

// dsp_ctr_nd_chk: status invariants of the run controller.
module dsp_ctr_nd_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic done
);

    // done marks IDLE entry, so it never coincides with busy.
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst) done |-> !busy);

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst) done |=> !done);

endmodule
